spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have no parameters; the clock divider is a run-time input.
REQ-002 clk  input  1  system clock; all logic in this single domain, rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 clkdiv  input  16  SCK half-period in clk cycles, latched at byte acceptance.
REQ-005 cs_assert  input  1  host request for chip select; high = select slave.
REQ-006 tx_data_valid  input  1  one-cycle strobe to start a byte.
REQ-007 tx_data  input  8  byte to shift out, MSB first, captured with tx_data_valid.
REQ-008 busy  output  1  high while a byte is in flight.
REQ-009 rx_data_valid  output  1  one-cycle strobe marking the received byte.
REQ-010 rx_data  output  8  byte shifted in from spi_miso, held until next completion.
REQ-011 spi_sck  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-012 spi_mosi  output  1  SPI data to slave.
REQ-013 spi_miso  input  1  SPI data from slave; synchronous to clk, no synchroniser.
REQ-014 spi_cs_n  output  1  chip select, active-low, registered.

Function
REQ-015 SHALL implement states IDLE, LOW (SCK low phase) and HIGH (SCK high phase).
REQ-016 IDLE, tx_data_valid=1 -> latch tx_data and effective clkdiv, set busy, enter LOW next cycle (cycle 1).
REQ-017 Effective clkdiv SHALL be max(clkdiv, 2); 0 and 1 are treated as 2.
REQ-018 From cycle 1, spi_mosi SHALL present the current bit, starting with bit 7.
REQ-019 LOW lasting clkdiv cycles -> spi_sck=1, spi_miso sampled into shift register LSB on that same edge, enter HIGH.
REQ-020 HIGH lasting clkdiv cycles -> spi_sck=0, bit counter increments, next bit driven on spi_mosi, enter LOW.
REQ-021 After the 8th HIGH phase, at cycle 1+16*clkdiv: spi_sck=0, rx_data updated, rx_data_valid=1 for one cycle, busy=0, enter IDLE.
REQ-022 tx_data_valid SHALL be ignored while busy=1; no queuing.
REQ-023 tx_data_valid in the same cycle as completion (busy still 1) SHALL be ignored; the earliest accepted strobe is the cycle after rx_data_valid.
REQ-024 Changes to clkdiv while busy SHALL NOT affect the byte in flight.
REQ-025 spi_cs_n SHALL equal ~cs_assert one cycle later when in IDLE; while busy, cs_assert changes SHALL be deferred until IDLE.
REQ-026 A byte SHALL shift regardless of spi_cs_n state; framing is the host's responsibility.
REQ-027 spi_sck SHALL be 0 whenever in IDLE.
REQ-028 spi_mosi SHALL hold the last driven bit in IDLE.

Reset
REQ-029 rst_n=0 at a clk edge -> state IDLE, busy=0, rx_data_valid=0, rx_data=0, spi_sck=0, spi_mosi=0, spi_cs_n=1, counters 0.
REQ-030 Reset mid-byte SHALL abort the byte with no rx_data_valid pulse and leave rx_data=0.
REQ-031 First tx_data_valid SHALL be honoured on the first cycle with rst_n=1.

Structure
REQ-032 The state enum and the minimum-divider constant (2) SHALL be declared in a shared package, spi_pkg, for reuse by SPISlave benches.
REQ-033 The block SHALL be a single module with no sub-modules; the divider counter is internal.

Verification
REQ-034 Test 1, loopback: spi_mosi tied to spi_miso, clkdiv=4, tx_data=0xA5 -> rx_data=0xA5, rx_data_valid at cycle 65, exactly 8 spi_sck rising edges.
REQ-035 Test 2, slave model driving 0x3C: tx_data=0xFF, clkdiv=2 -> rx_data=0x3C at cycle 33; spi_mosi high on every rising spi_sck edge.
REQ-036 Test 3, busy and back-to-back: strobe while busy, then strobe on the cycle after rx_data_valid -> first ignored, second accepted; spi_sck low for at least 1 cycle between bytes.
REQ-037 Test 4, clkdiv=0: -> identical timing to clkdiv=2 (rx_data_valid at cycle 33).
REQ-038 Test 5, reset and CS deferral: rst_n=0 at cycle 20 of a byte -> all REQ-029 values next cycle, no rx_data_valid; then cs_assert toggled mid-byte -> spi_cs_n changes only after busy falls.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states and the divider floor.
// Also imported by slave-side benches that need the same encoding.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } spi_state_e;

   localparam logic [15:0] MIN_CLKDIV = 16'd2;

   // Dividers below the floor would collapse an SCK phase to zero or one cycle.
   function automatic logic [15:0] eff_clkdiv(input logic [15:0] div);
      return (div < MIN_CLKDIV) ? MIN_CLKDIV : div;
   endfunction

endpackage

// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per strobe, MSB first, run-time SCK divider.
// All outputs are registered; busy is derived from the registered state.
module spi_master
   import spi_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] clkdiv,
   input  logic        cs_assert,
   input  logic        tx_data_valid,
   input  logic [7:0]  tx_data,
   output logic        busy,
   output logic        rx_data_valid,
   output logic [7:0]  rx_data,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        spi_cs_n
);

   spi_state_e  state_q, state_d;
   logic [15:0] div_q, div_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  sh_q, sh_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        sck_q, sck_d;
   logic        mosi_q, mosi_d;
   logic        cs_n_q, cs_n_d;
   logic        phase_end;

   assign phase_end = (cnt_q == div_q - 16'd1);

   // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      sh_d       = sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;

      unique case (state_q)
         IDLE: begin
            cs_n_d = ~cs_assert;
            sck_d  = 1'b0;
            if (tx_data_valid) begin
               state_d = LOW;
               div_d   = eff_clkdiv(clkdiv);
               cnt_d   = 16'd0;
               bit_d   = 3'd0;
               sh_d    = tx_data;
               mosi_d  = tx_data[7];
            end
         end
         LOW: begin
            if (phase_end) begin
               // Rising SCK edge: slave data is captured on the same clk edge.
               cnt_d   = 16'd0;
               sck_d   = 1'b1;
               sh_d    = {sh_q[6:0], spi_miso};
               state_d = HIGH;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         HIGH: begin
            if (phase_end) begin
               cnt_d = 16'd0;
               sck_d = 1'b0;
               if (bit_q == 3'd7) begin
                  state_d    = IDLE;
                  bit_d      = 3'd0;
                  rx_data_d  = sh_q;
                  rx_valid_d = 1'b1;
               end else begin
                  state_d = LOW;
                  bit_d   = bit_q + 3'd1;
                  mosi_d  = sh_q[7];
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments only; reset is synchronous.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         div_q      <= MIN_CLKDIV;
         cnt_q      <= 16'd0;
         bit_q      <= 3'd0;
         sh_q       <= 8'd0;
         rx_data_q  <= 8'd0;
         rx_valid_q <= 1'b0;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         sh_q       <= sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
      end
   end

   assign busy          = (state_q != IDLE);
   assign rx_data_valid = rx_valid_q;
   assign rx_data       = rx_data_q;
   assign spi_sck       = sck_q;
   assign spi_mosi      = mosi_q;
   assign spi_cs_n      = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: scoreboard of expected bytes and completion cycles.
// Outputs are sampled on the falling clk edge; stimulus is driven there too.
module tb_spi_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] clkdiv;
   logic        cs_assert;
   logic        tx_data_valid;
   logic [7:0]  tx_data;
   logic        busy;
   logic        rx_data_valid;
   logic [7:0]  rx_data;
   logic        spi_sck;
   logic        spi_mosi;
   logic        spi_miso;
   logic        spi_cs_n;

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t       sb[$];
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         last_due = 0;
   int         rise_cnt = 0;
   int         fall_cnt = 0;
   int         fall_base = 0;
   bit         prev_sck = 1'b0;
   bit         loop_en = 1'b1;
   bit         chk_mosi_hi = 1'b0;
   logic [7:0] slave_byte = 8'h00;
   logic       slave_bit;

   spi_master dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clkdiv       (clkdiv),
      .cs_assert    (cs_assert),
      .tx_data_valid(tx_data_valid),
      .tx_data      (tx_data),
      .busy         (busy),
      .rx_data_valid(rx_data_valid),
      .rx_data      (rx_data),
      .spi_sck      (spi_sck),
      .spi_mosi     (spi_mosi),
      .spi_miso     (spi_miso),
      .spi_cs_n     (spi_cs_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Mode-0 slave: presents bit 7 first, advances after each falling SCK edge.
   always_comb begin
      int idx;
      idx       = fall_cnt - fall_base;
      slave_bit = 1'b0;
      if (idx >= 0 && idx <= 7) slave_bit = slave_byte[7 - idx];
   end

   assign spi_miso = loop_en ? spi_mosi : slave_bit;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (spi_sck && !prev_sck) begin
         rise_cnt++;
         if (chk_mosi_hi) check("mosi_at_rise", spi_mosi, 1);
      end
      if (!spi_sck && prev_sck) fall_cnt++;
      prev_sck = spi_sck;
      if (rx_data_valid) begin
         if (sb.size() == 0) begin
            check("rx_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rx_data", rx_data, e.data);
            check("rx_cycle", cyc, e.due);
         end
      end
   end

   // Called at a falling edge; the strobe is sampled by the next rising edge (cycle 0).
   task automatic send(input logic [7:0] d, input logic [15:0] div,
                       input logic [7:0] exp_rx, input bit expect_rx);
      int eff;
      eff           = (div < 16'd2) ? 2 : int'(div);
      tx_data       = d;
      clkdiv        = div;
      tx_data_valid = 1'b1;
      last_due      = cyc + 1 + 16 * eff;
      if (expect_rx) sb.push_back('{exp_rx, last_due});
      @(negedge clk);
      tx_data_valid = 1'b0;
   endtask

   task automatic wait_rx();
      int n;
      n = 0;
      @(negedge clk);
      while (!rx_data_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!rx_data_valid) check("rx_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      rst_n         = 1'b0;
      clkdiv        = 16'd4;
      cs_assert     = 1'b0;
      tx_data_valid = 1'b0;
      tx_data       = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_rxv", rx_data_valid, 0);
      check("rst_rxd", rx_data, 8'h00);
      check("rst_sck", spi_sck, 0);
      check("rst_mosi", spi_mosi, 0);
      check("rst_csn", spi_cs_n, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Test 1: loopback 0xA5, clkdiv=4, divider changed mid-byte.
      base = rise_cnt;
      send(8'hA5, 16'd4, 8'hA5, 1'b1);
      check("t1_busy", busy, 1);
      clkdiv = 16'd9;
      wait_rx();
      check("t1_rises", rise_cnt - base, 8);
      check("t1_sck_idle", spi_sck, 0);
      @(negedge clk);
      check("t1_mosi_hold", spi_mosi, 1);

      // Test 2: slave returns 0x3C while master sends 0xFF at clkdiv=2.
      loop_en     = 1'b0;
      slave_byte  = 8'h3C;
      fall_base   = fall_cnt;
      chk_mosi_hi = 1'b1;
      send(8'hFF, 16'd2, 8'h3C, 1'b1);
      wait_rx();
      chk_mosi_hi = 1'b0;
      loop_en     = 1'b1;
      @(negedge clk);

      // Test 3: strobes while busy and in the completion cycle are dropped.
      send(8'h5A, 16'd2, 8'h5A, 1'b1);
      repeat (4) @(negedge clk);
      check("t3_busy", busy, 1);
      tx_data       = 8'h11;
      tx_data_valid = 1'b1;
      @(negedge clk);
      tx_data_valid = 1'b0;
      n = 0;
      while (cyc != last_due - 1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t3_busy_last", busy, 1);
      tx_data       = 8'h22;
      tx_data_valid = 1'b1;
      @(negedge clk);
      tx_data_valid = 1'b0;
      check("t3_sck_gap0", spi_sck, 0);
      @(negedge clk);
      check("t3_not_taken", busy, 0);
      check("t3_sck_gap1", spi_sck, 0);
      send(8'hC3, 16'd2, 8'hC3, 1'b1);
      check("t3_taken", busy, 1);
      wait_rx();
      @(negedge clk);

      // Test 4: clkdiv=0 behaves as clkdiv=2.
      send(8'h96, 16'd0, 8'h96, 1'b1);
      wait_rx();
      @(negedge clk);

      // Test 5: mid-byte reset, strobe on first cycle out of reset, CS deferral.
      cs_assert = 1'b1;
      send(8'hE7, 16'd4, 8'h00, 1'b0);
      repeat (18) @(negedge clk);
      check("t5_cs_sel", spi_cs_n, 0);
      rst_n = 1'b0;
      @(negedge clk);
      check("t5_busy", busy, 0);
      check("t5_rxv", rx_data_valid, 0);
      check("t5_rxd", rx_data, 8'h00);
      check("t5_sck", spi_sck, 0);
      check("t5_mosi", spi_mosi, 0);
      check("t5_csn", spi_cs_n, 1);
      rst_n = 1'b1;
      send(8'h81, 16'd2, 8'h81, 1'b1);
      check("t5_first_strobe", busy, 1);
      check("t5_cs_after_rst", spi_cs_n, 0);
      repeat (5) @(negedge clk);
      cs_assert = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_cs_defer", spi_cs_n, 0);
      wait_rx();
      check("t5_cs_at_done", spi_cs_n, 0);
      @(negedge clk);
      check("t5_cs_release", spi_cs_n, 1);

      repeat (5) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
